// File: rtl/opc_boot_ctrl.sv
// Boot/run sequencer for the OPC CPU: loads a byte stream into the shared 4K x 8 RAM, holds the CPU in reset, then hands it the bus.
// Optional load checksum verification is enabled by defining BOOT_CHECKSUM_EN.
module opc_boot_ctrl #(
  parameter logic [11:0] BOOT_ADDR   = 12'h000,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        ld_start,
  input  logic        run_req,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic [11:0] cpu_address,
  input  logic        cpu_rnw,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_reset_b,
  output logic [11:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);
  localparam logic [11:0] TOP_ADDR = 12'hFFF;

  state_t      state;
  logic [11:0] ptr;
  logic [3:0]  hold_cnt;
  logic        accept;
  logic        sum_ok;

  assign accept = ld_ready & ld_valid;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_nxt;

  // The last byte is included, so a good image sums to zero.
  assign sum_nxt = sum + ld_data;
  assign sum_ok  = (sum_nxt == 8'h00);

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      sum <= 8'h00;
    end else if ((state == IDLE || state == RUN) && ld_start) begin
      sum <= 8'h00;
    end else if (accept) begin
      sum <= sum_nxt;
    end
  end
`else
  assign sum_ok = 1'b1;
`endif

  // Outputs are registered alongside each transition so they track the state exactly.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state       <= IDLE;
      ptr         <= BOOT_ADDR;
      hold_cnt    <= 4'd0;
      err         <= 1'b0;
      cpu_reset_b <= 1'b0;
      ld_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_start) begin
            state    <= LOAD;
            ptr      <= BOOT_ADDR;
            err      <= 1'b0;
            ld_ready <= 1'b1;
            busy     <= 1'b1;
          end else if (run_req) begin
            state    <= HOLD;
            hold_cnt <= HOLD_INIT;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            // Saturate at the top so a runaway stream never overwrites low memory.
            if (ptr != TOP_ADDR) begin
              ptr <= ptr + 12'd1;
            end
            if (ld_last && sum_ok) begin
              state    <= HOLD;
              hold_cnt <= HOLD_INIT;
              ld_ready <= 1'b0;
            end else if (ld_last || ptr == TOP_ADDR) begin
              state    <= IDLE;
              err      <= 1'b1;
              ld_ready <= 1'b0;
              busy     <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == 4'd0) begin
            state       <= RUN;
            cpu_reset_b <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        RUN: begin
          if (ld_start) begin
            state       <= LOAD;
            ptr         <= BOOT_ADDR;
            err         <= 1'b0;
            cpu_reset_b <= 1'b0;
            done        <= 1'b0;
            ld_ready    <= 1'b1;
            busy        <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_address = ptr;
    mem_wdata   = ld_data;
    mem_we      = accept;
    cpu_din     = 8'h00;
    if (state == RUN) begin
      mem_address = cpu_address;
      mem_wdata   = cpu_dout;
      mem_we      = ~cpu_rnw;
      cpu_din     = mem_rdata;
    end
  end

endmodule
